shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 104 ++++++++++
 tb/tb_shift_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle logical shifter: captures an operand, then shifts it in coarse STEP
// strides and single-bit strides until the requested amount is used up.
module shift_sequencer #(
   parameter int unsigned BUS   = 32,
   parameter int unsigned STEP  = 4,
   parameter int unsigned AMT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             dirc,
   input  logic [AMT_W-1:0] shamt,
   input  logic [BUS-1:0]   data_in,
   output logic [BUS-1:0]   data_out,
   output logic             busy,
   output logic             done
);

   localparam int unsigned REM_W = $clog2(BUS) + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_next;
   logic [REM_W-1:0] rem, rem_next;
   logic             dir, dir_next;
   logic [BUS-1:0]   data_next;
   logic             busy_next, done_next;
   logic [REM_W-1:0] rem_cap;
   logic [REM_W-1:0] dec;
   logic [BUS-1:0]   shifted;
   logic             capture;

   // Saturate the requested amount to the bus width
   always_comb begin
      if (32'(shamt) >= 32'(BUS)) rem_cap = REM_W'(BUS);
      else                        rem_cap = REM_W'(shamt);
   end

   // One shift step: coarse stride while enough remains, else a single bit
   always_comb begin
      if (rem >= REM_W'(STEP)) begin
         dec     = REM_W'(STEP);
         shifted = dir ? (data_out << STEP) : (data_out >> STEP);
      end else begin
         dec     = REM_W'(1);
         shifted = dir ? (data_out << 1) : (data_out >> 1);
      end
   end

   // A start is honoured in IDLE and on the edge leaving DONE; abort always wins
   assign capture = start && !abort && (state == IDLE || state == DONE);

   always_comb begin
      state_next = state;
      data_next  = data_out;
      rem_next   = rem;
      dir_next   = dir;
      if (capture) begin
         data_next  = data_in;
         dir_next   = dirc;
         rem_next   = rem_cap;
         state_next = (rem_cap != '0) ? SHIFT : DONE;
      end else begin
         case (state)
            IDLE:  state_next = IDLE;
            SHIFT: begin
               if (abort) begin
                  state_next = IDLE;
               end else if (rem == '0) begin
                  state_next = DONE;
               end else begin
                  data_next = shifted;
                  rem_next  = rem - dec;
                  if (rem == dec) state_next = DONE;
               end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
      busy_next = (state_next != IDLE);
      done_next = (state_next == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         data_out <= '0;
         rem      <= '0;
         dir      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_next;
         data_out <= data_next;
         rem      <= rem_next;
         dir      <= dir_next;
         busy     <= busy_next;
         done     <= done_next;
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (BUS=32, STEP=4).
module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic        dirc;
   logic [5:0]  shamt;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   shift_sequencer #(.BUS(32), .STEP(4), .AMT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dirc(dirc),
      .shamt(shamt), .data_in(data_in), .data_out(data_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one capture edge, then releases start
   task automatic launch(input logic d, input logic [5:0] amt, input logic [31:0] val);
      dirc = d; shamt = amt; data_in = val; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Counts edges until done is seen (bounded); reports whether busy stayed high
   task automatic wait_done(output int n, output logic all_busy);
      n = 0;
      all_busy = busy;
      while (!done && n < 50) begin
         tick();
         n++;
         if (!busy) all_busy = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; dirc = 1'b0; shamt = '0; data_in = '0;
      tick(); tick();
      n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want %h", data_out, 32'h0); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_left6();
      int n; logic ab;
      launch(1'b1, 6'd6, 32'h0000_0001);
      n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL left6_start: got busy=%b done=%b want 1 0", busy, done); end
      wait_done(n, ab);
      n_checks++; if (n !== 3) begin n_fail++; $display("FAIL left6_latency: got %0d want 3", n); end
      n_checks++; if (ab !== 1'b1) begin n_fail++; $display("FAIL left6_busy: got %b want 1", ab); end
      n_checks++; if (data_out !== 32'h0000_0040) begin n_fail++; $display("FAIL left6_data: got %h want %h", data_out, 32'h40); end
      tick();
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL left6_idle: got done=%b busy=%b want 0 0", done, busy); end
      n_checks++; if (data_out !== 32'h0000_0040) begin n_fail++; $display("FAIL left6_hold: got %h want %h", data_out, 32'h40); end
   endtask

   task automatic test_zero();
      int n; logic ab;
      launch(1'b0, 6'd0, 32'hDEAD_BEEF);
      wait_done(n, ab);
      n_checks++; if (n !== 0) begin n_fail++; $display("FAIL zero_latency: got %0d want 0", n); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy: got %b want 1", busy); end
      n_checks++; if (data_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL zero_data: got %h want %h", data_out, 32'hDEAD_BEEF); end
      tick();
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL zero_after: got busy=%b done=%b want 0 0", busy, done); end
   endtask

   task automatic test_right();
      int n; logic ab;
      launch(1'b0, 6'd5, 32'h8000_0000);
      wait_done(n, ab);
      n_checks++; if (n !== 2) begin n_fail++; $display("FAIL right5_latency: got %0d want 2", n); end
      n_checks++; if (data_out !== 32'h0400_0000) begin n_fail++; $display("FAIL right5_data: got %h want %h", data_out, 32'h0400_0000); end
      tick();
      launch(1'b1, 6'd4, 32'h0000_0A5F);
      wait_done(n, ab);
      n_checks++; if (n !== 1) begin n_fail++; $display("FAIL step4_latency: got %0d want 1", n); end
      n_checks++; if (data_out !== 32'h0000_A5F0) begin n_fail++; $display("FAIL step4_data: got %h want %h", data_out, 32'hA5F0); end
      tick();
   endtask

   task automatic test_saturate();
      int n; logic ab;
      launch(1'b0, 6'd40, 32'hFFFF_FFFF);
      wait_done(n, ab);
      n_checks++; if (n !== 8) begin n_fail++; $display("FAIL sat40_latency: got %0d want 8", n); end
      n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL sat40_data: got %h want 0", data_out); end
      tick();
      launch(1'b1, 6'd32, 32'hFFFF_FFFF);
      wait_done(n, ab);
      n_checks++; if (n !== 8) begin n_fail++; $display("FAIL sat32_latency: got %0d want 8", n); end
      n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL sat32_data: got %h want 0", data_out); end
      tick();
   endtask

   task automatic test_back_to_back();
      int n; logic ab;
      launch(1'b1, 6'd8, 32'h0000_00FF);
      dirc = 1'b0; shamt = 6'd1; data_in = 32'h1234_5678; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(n, ab);
      n_checks++; if (n !== 1) begin n_fail++; $display("FAIL b2b_latency: got %0d want 1", n); end
      n_checks++; if (data_out !== 32'h0000_FF00) begin n_fail++; $display("FAIL b2b_data: got %h want %h", data_out, 32'hFF00); end
      dirc = 1'b1; shamt = 6'd1; data_in = 32'h0000_0003; start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++; if (data_out !== 32'h0000_0003) begin n_fail++; $display("FAIL held_capture: got %h want %h", data_out, 32'h3); end
      n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL held_state: got busy=%b done=%b want 1 0", busy, done); end
      tick();
      n_checks++; if (done !== 1'b1 || data_out !== 32'h0000_0006) begin n_fail++; $display("FAIL held_result: got done=%b data=%h want 1 %h", done, data_out, 32'h6); end
      tick();
   endtask

   task automatic test_abort();
      logic seen;
      launch(1'b1, 6'd12, 32'h0000_0001);
      tick();
      n_checks++; if (data_out !== 32'h0000_0010) begin n_fail++; $display("FAIL abort_partial: got %h want %h", data_out, 32'h10); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%b done=%b want 0 0", busy, done); end
      n_checks++; if (data_out !== 32'h0000_0010) begin n_fail++; $display("FAIL abort_hold: got %h want %h", data_out, 32'h10); end
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (done || busy) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b want 0", seen); end
      abort = 1'b1; start = 1'b1; dirc = 1'b1; shamt = 6'd2; data_in = 32'h0000_0007;
      tick();
      abort = 1'b0; start = 1'b0;
      n_checks++; if (busy !== 1'b0 || data_out !== 32'h0000_0010) begin n_fail++; $display("FAIL abort_idle_start: got busy=%b data=%h want 0 %h", busy, data_out, 32'h10); end
   endtask

   task automatic test_reset_mid();
      logic seen;
      launch(1'b1, 6'd12, 32'h0000_0001);
      tick();
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (data_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid: got data=%h busy=%b done=%b want 0 0 0", data_out, busy, done); end
      seen = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (done || busy) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_hold: got %b want 0", seen); end
      rst_n = 1'b1;
      launch(1'b1, 6'd1, 32'h0000_0005);
      n_checks++; if (data_out !== 32'h0000_0005 || busy !== 1'b1) begin n_fail++; $display("FAIL rst_first_start: got data=%h busy=%b want %h 1", data_out, busy, 32'h5); end
      tick();
      n_checks++; if (done !== 1'b1 || data_out !== 32'h0000_000A) begin n_fail++; $display("FAIL rst_first_result: got done=%b data=%h want 1 %h", done, data_out, 32'hA); end
      tick();
   endtask

   initial begin
      test_reset();
      test_left6();
      test_zero();
      test_right();
      test_saturate();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
